// File: rtl/jtframe_pxl_timer.sv
// Video timing generator: H/V position counters plus blanking, sync and
// line/frame markers, all advancing only on pixel clock enable edges.
module jtframe_pxl_timer #(
    parameter int HW       = 9,
    parameter int VW       = 9,
    parameter int HTOTAL   = 384,
    parameter int HB_START = 256,
    parameter int HS_START = 288,
    parameter int HS_END   = 320,
    parameter int VTOTAL   = 262,
    parameter int VB_END   = 16,
    parameter int VB_START = 240,
    parameter int VS_START = 244,
    parameter int VS_END   = 247
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pxl_cen,
    output logic [HW-1:0] H,
    output logic [VW-1:0] V,
    output logic          LHBL,
    output logic          LVBL,
    output logic          HS,
    output logic          VS,
    output logic          HINIT,
    output logic          VINIT,
    output logic          frame
);

    localparam logic [HW-1:0] HLAST = HW'(HTOTAL - 1);
    localparam logic [HW-1:0] HBS   = HW'(HB_START);
    localparam logic [HW-1:0] HSS   = HW'(HS_START);
    localparam logic [HW-1:0] HSE   = HW'(HS_END);
    localparam logic [VW-1:0] VLAST = VW'(VTOTAL - 1);
    localparam logic [VW-1:0] VBE   = VW'(VB_END);
    localparam logic [VW-1:0] VBS   = VW'(VB_START);
    localparam logic [VW-1:0] VSS   = VW'(VS_START);
    localparam logic [VW-1:0] VSE   = VW'(VS_END);

    logic          h_last;
    logic          v_last;
    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt;

    // Wrap explicitly at the totals so non-power-of-two geometries work
    always_comb begin
        h_last = (H == HLAST);
        v_last = (V == VLAST);
        h_nxt  = h_last ? '0 : H + HW'(1);
        v_nxt  = V;
        if (h_last) begin
            v_nxt = v_last ? '0 : V + VW'(1);
        end
    end

    // Decoded outputs come from the next counter values so they line up
    // with the H/V values registered on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            H     <= '0;
            V     <= '0;
            LHBL  <= 1'b1;
            LVBL  <= 1'b0;
            HS    <= 1'b0;
            VS    <= 1'b0;
            HINIT <= 1'b1;
            VINIT <= 1'b1;
            frame <= 1'b0;
        end else if (pxl_cen) begin
            H     <= h_nxt;
            V     <= v_nxt;
            LHBL  <= !(h_nxt >= HBS);
            LVBL  <= !((v_nxt < VBE) || (v_nxt >= VBS));
            HS    <= (h_nxt >= HSS) && (h_nxt < HSE);
            HINIT <= (h_nxt == '0);
            VINIT <= (h_nxt == '0) && (v_nxt == '0);
            frame <= frame ^ (h_last & v_last);
            if (h_nxt == HSS) begin
                if (v_nxt == VSS) begin
                    VS <= 1'b1;
                end else if (v_nxt == VSE) begin
                    VS <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtframe_pxl_timer.sv
// Directed bench for jtframe_pxl_timer: default geometry, a tall narrow
// geometry for full-frame vertical timing, and a tiny override geometry.
module tb_jtframe_pxl_timer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: default parameters
    logic       rst_a = 1'b0, cen_a = 1'b0;
    logic [8:0] ha, va;
    logic       lhbl_a, lvbl_a, hs_a, vs_a, hinit_a, vinit_a, frame_a;
    logic [24:0] obs_a;
    assign obs_a = {ha, va, lhbl_a, lvbl_a, hs_a, vs_a, hinit_a, vinit_a, frame_a};

    jtframe_pxl_timer u_a (
        .clk(clk), .rst_n(rst_a), .pxl_cen(cen_a), .H(ha), .V(va),
        .LHBL(lhbl_a), .LVBL(lvbl_a), .HS(hs_a), .VS(vs_a),
        .HINIT(hinit_a), .VINIT(vinit_a), .frame(frame_a)
    );

    // Instance B: short lines, default vertical timing
    logic       rst_b = 1'b0, cen_b = 1'b0;
    logic [8:0] hb, vb;
    logic       lhbl_b, lvbl_b, hs_b, vs_b, hinit_b, vinit_b, frame_b;

    jtframe_pxl_timer #(.HTOTAL(40), .HB_START(30), .HS_START(32), .HS_END(36)) u_b (
        .clk(clk), .rst_n(rst_b), .pxl_cen(cen_b), .H(hb), .V(vb),
        .LHBL(lhbl_b), .LVBL(lvbl_b), .HS(hs_b), .VS(vs_b),
        .HINIT(hinit_b), .VINIT(vinit_b), .frame(frame_b)
    );

    // Instance C: tiny geometry filling its counter widths exactly
    logic       rst_c = 1'b0, cen_c = 1'b1;
    logic [3:0] hc;
    logic [1:0] vc;
    logic       lhbl_c, lvbl_c, hs_c, vs_c, hinit_c, vinit_c, frame_c;

    jtframe_pxl_timer #(.HW(4), .VW(2), .HTOTAL(16), .HB_START(12), .HS_START(13),
                        .HS_END(14), .VTOTAL(4), .VB_END(1), .VB_START(3),
                        .VS_START(2), .VS_END(3)) u_c (
        .clk(clk), .rst_n(rst_c), .pxl_cen(cen_c), .H(hc), .V(vc),
        .LHBL(lhbl_c), .LVBL(lvbl_c), .HS(hs_c), .VS(vs_c),
        .HINIT(hinit_c), .VINIT(vinit_c), .frame(frame_c)
    );

    task automatic pix_a();
        @(negedge clk); cen_a = 1'b1;
        @(negedge clk); cen_a = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [24:0] exp;
        exp = {9'd0, 9'd0, 7'b1000110};
        @(negedge clk);
        checks++;
        if (obs_a !== exp) begin
            failures++;
            $display("[TB] FAIL reset_state got=%h exp=%h", obs_a, exp);
        end
        cen_a = 1'b1;
        repeat (3) @(negedge clk);
        cen_a = 1'b0;
        checks++;
        if (obs_a !== exp) begin
            failures++;
            $display("[TB] FAIL reset_held got=%h exp=%h", obs_a, exp);
        end
    endtask

    task automatic test_line();
        logic [24:0] exp;
        logic [8:0]  eh;
        int          bad = 0;
        int          hs_cnt = 0;
        @(negedge clk); rst_a = 1'b1;
        for (int i = 1; i < 384; i++) begin
            pix_a();
            eh  = i[8:0];
            exp = {eh, 9'd0, (i < 256), 1'b0, (i >= 288 && i < 320), 4'b0000};
            hs_cnt += int'(hs_a);
            checks++;
            if (obs_a !== exp) begin
                failures++;
                bad++;
                if (bad < 5) $display("[TB] FAIL line_pixel_%0d got=%h exp=%h", i, obs_a, exp);
            end
        end
        checks++;
        if (hs_cnt != 32) begin
            failures++;
            $display("[TB] FAIL hs_width got=%0d exp=32", hs_cnt);
        end
    endtask

    task automatic test_line_wrap();
        logic [24:0] exp;
        int hinit_cnt;
        int vinit_cnt;
        exp = {9'd0, 9'd1, 7'b1000100};
        @(negedge clk); cen_a = 1'b1;
        @(negedge clk); cen_a = 1'b0;
        checks++;
        if (obs_a !== exp) begin
            failures++;
            $display("[TB] FAIL line_wrap got=%h exp=%h", obs_a, exp);
        end
        hinit_cnt = int'(hinit_a);
        vinit_cnt = int'(vinit_a);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            hinit_cnt += int'(hinit_a);
            vinit_cnt += int'(vinit_a);
            cen_a = (k == 2);
        end
        checks++;
        if (hinit_cnt != 4) begin
            failures++;
            $display("[TB] FAIL hinit_clks got=%0d exp=4", hinit_cnt);
        end
        checks++;
        if (vinit_cnt != 0) begin
            failures++;
            $display("[TB] FAIL vinit_line1 got=%0d exp=0", vinit_cnt);
        end
    endtask

    task automatic test_gating();
        logic [24:0] exp;
        int bad = 0;
        repeat (99) pix_a();
        exp = {9'd100, 9'd1, 7'b1000000};
        checks++;
        if (obs_a !== exp) begin
            failures++;
            $display("[TB] FAIL gate_start got=%h exp=%h", obs_a, exp);
        end
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (obs_a !== exp) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL gate_hold got=%0d exp=0 changed cycles", bad);
        end
        pix_a();
        exp = {9'd101, 9'd1, 7'b1000000};
        checks++;
        if (obs_a !== exp) begin
            failures++;
            $display("[TB] FAIL gate_resume got=%h exp=%h", obs_a, exp);
        end
    endtask

    task automatic test_async_reset_a();
        logic [24:0] exp;
        @(negedge clk); cen_a = 1'b1;
        repeat (482) @(negedge clk);
        @(negedge clk); cen_a = 1'b0;
        exp = {9'd200, 9'd2, 7'b1000000};
        checks++;
        if (obs_a !== exp) begin
            failures++;
            $display("[TB] FAIL fast_run got=%h exp=%h", obs_a, exp);
        end
        #2 rst_a = 1'b0;
        #1;
        exp = {9'd0, 9'd0, 7'b1000110};
        checks++;
        if (obs_a !== exp) begin
            failures++;
            $display("[TB] FAIL async_reset_a got=%h exp=%h", obs_a, exp);
        end
        @(negedge clk); rst_a = 1'b1;
        pix_a();
        exp = {9'd1, 9'd0, 7'b1000000};
        checks++;
        if (obs_a !== exp) begin
            failures++;
            $display("[TB] FAIL release_first got=%h exp=%h", obs_a, exp);
        end
    endtask

    task automatic test_full_frame();
        int pos_bad = 0, ftog = 0;
        int lv_rise = -1, lv_fall = -1, vs_rise = -1, vs_fall = -1, fpos = -1;
        int h, v;
        logic plv, pvs, pfr;
        @(negedge clk); rst_b = 1'b1; cen_b = 1'b1;
        plv = lvbl_b; pvs = vs_b; pfr = frame_b;
        for (int n = 1; n <= 10480; n++) begin
            @(negedge clk);
            h = n % 40;
            v = (n / 40) % 262;
            if (int'(hb) != h || int'(vb) != v) pos_bad++;
            if (!plv && lvbl_b && lv_rise < 0) lv_rise = v * 1000 + h;
            if (plv && !lvbl_b && lv_fall < 0) lv_fall = v * 1000 + h;
            if (!pvs && vs_b && vs_rise < 0) vs_rise = v * 1000 + h;
            if (pvs && !vs_b && vs_fall < 0) vs_fall = v * 1000 + h;
            if (pfr !== frame_b) begin ftog++; fpos = v * 1000 + h; end
            plv = lvbl_b; pvs = vs_b; pfr = frame_b;
        end
        checks++;
        if (pos_bad != 0) begin failures++; $display("[TB] FAIL frame_counters got=%0d exp=0 bad cycles", pos_bad); end
        checks++;
        if (lv_rise != 16000) begin failures++; $display("[TB] FAIL lvbl_rise got=%0d exp=16000", lv_rise); end
        checks++;
        if (lv_fall != 240000) begin failures++; $display("[TB] FAIL lvbl_fall got=%0d exp=240000", lv_fall); end
        checks++;
        if (vs_rise != 244032) begin failures++; $display("[TB] FAIL vs_rise got=%0d exp=244032", vs_rise); end
        checks++;
        if (vs_fall != 247032) begin failures++; $display("[TB] FAIL vs_fall got=%0d exp=247032", vs_fall); end
        checks++;
        if (ftog != 1 || fpos != 0) begin failures++; $display("[TB] FAIL frame_toggle got=%0d@%0d exp=1@0", ftog, fpos); end
    endtask

    task automatic test_async_reset_b();
        repeat (4820) @(negedge clk);
        cen_b = 1'b0;
        checks++;
        if ({hb, vb, lvbl_b, frame_b} !== {9'd20, 9'd120, 1'b1, 1'b1}) begin
            failures++;
            $display("[TB] FAIL midframe_pos got=%h exp=%h", {hb, vb, lvbl_b, frame_b}, {9'd20, 9'd120, 1'b1, 1'b1});
        end
        #2 rst_b = 1'b0;
        #1;
        checks++;
        if ({hb, vb, lhbl_b, lvbl_b, hs_b, vs_b, frame_b} !== {9'd0, 9'd0, 5'b10000}) begin
            failures++;
            $display("[TB] FAIL async_reset_b got=%h exp=%h", {hb, vb, lhbl_b, lvbl_b, hs_b, vs_b, frame_b}, {9'd0, 9'd0, 5'b10000});
        end
    endtask

    task automatic test_override();
        int pos_bad = 0, hs_cnt = 0, hbl_cnt = 0, vbl_cnt = 0;
        int vs_rise = -1, vs_fall = -1;
        int h, v;
        logic pvs;
        @(negedge clk); rst_c = 1'b1;
        pvs = vs_c;
        for (int n = 1; n <= 64; n++) begin
            @(negedge clk);
            h = n % 16;
            v = (n / 16) % 4;
            if (int'(hc) != h || int'(vc) != v) pos_bad++;
            hs_cnt  += int'(hs_c);
            hbl_cnt += int'(!lhbl_c);
            vbl_cnt += int'(!lvbl_c);
            if (!pvs && vs_c && vs_rise < 0) vs_rise = v * 100 + h;
            if (pvs && !vs_c && vs_fall < 0) vs_fall = v * 100 + h;
            pvs = vs_c;
        end
        checks++;
        if (pos_bad != 0) begin failures++; $display("[TB] FAIL small_counters got=%0d exp=0 bad cycles", pos_bad); end
        checks++;
        if (vs_rise != 213) begin failures++; $display("[TB] FAIL small_vs_rise got=%0d exp=213", vs_rise); end
        checks++;
        if (vs_fall != 313) begin failures++; $display("[TB] FAIL small_vs_fall got=%0d exp=313", vs_fall); end
        checks++;
        if (hs_cnt != 4) begin failures++; $display("[TB] FAIL small_hs_cnt got=%0d exp=4", hs_cnt); end
        checks++;
        if (hbl_cnt != 16) begin failures++; $display("[TB] FAIL small_hblank_cnt got=%0d exp=16", hbl_cnt); end
        checks++;
        if (vbl_cnt != 32) begin failures++; $display("[TB] FAIL small_vblank_cnt got=%0d exp=32", vbl_cnt); end
        checks++;
        if ({hc, vc, frame_c, vinit_c} !== {4'd0, 2'd0, 1'b1, 1'b1}) begin
            failures++;
            $display("[TB] FAIL small_period got=%h exp=%h", {hc, vc, frame_c, vinit_c}, {4'd0, 2'd0, 1'b1, 1'b1});
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_line_wrap();
        test_gating();
        test_async_reset_a();
        test_full_frame();
        test_async_reset_b();
        test_override();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
